// File: rtl/gilbert_elliott_ctrl.sv
// Two-state Gilbert-Elliott channel-condition generator.
// A free-running Galois LFSR drives per-step Good/Bad transitions. The
// transitions are gated by programmable probabilities and a minimum dwell
// time. Burst statistics are kept alongside the channel state.
module gilbert_elliott_ctrl #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned MIN_DWELL = 4,
    parameter logic [4:0]  SNR_GOOD  = 5'd20,
    parameter logic [4:0]  SNR_BAD   = 5'd9,
    parameter int unsigned STAT_W    = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [7:0]        p_gb,
    input  logic [7:0]        p_bg,
    input  logic              stat_clr,
    output logic              state,
    output logic [4:0]        snr,
    output logic              burst_start,
    output logic [STAT_W-1:0] bad_steps,
    output logic [STAT_W-1:0] burst_count
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [7:0]  DWELL_MAX = 8'(MIN_DWELL);
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic {
        GOOD = 1'b0,
        BAD  = 1'b1
    } ch_state_t;

    ch_state_t          cur, nxt;
    logic [15:0]        lfsr, lfsr_nxt;
    logic [7:0]         dwell, dwell_nxt;
    logic [4:0]         snr_nxt;
    logic               bs_nxt;
    logic [STAT_W-1:0]  bad_nxt, burst_nxt;
    logic [7:0]         rnd, p;
    logic               hit, go;

    // State, LFSR, dwell and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur         <= GOOD;
            lfsr        <= SEED;
            dwell       <= '0;
            snr         <= SNR_GOOD;
            burst_start <= 1'b0;
            bad_steps   <= '0;
            burst_count <= '0;
        end else begin
            cur         <= nxt;
            lfsr        <= lfsr_nxt;
            dwell       <= dwell_nxt;
            snr         <= snr_nxt;
            burst_start <= bs_nxt;
            bad_steps   <= bad_nxt;
            burst_count <= burst_nxt;
        end
    end

    assign state = cur;

    // Step decision: transition test, next state, dwell, LFSR and statistics.
    always_comb begin
        nxt       = cur;
        lfsr_nxt  = lfsr;
        dwell_nxt = dwell;
        bs_nxt    = 1'b0;
        bad_nxt   = bad_steps;
        burst_nxt = burst_count;
        rnd       = lfsr[7:0];
        p         = (cur == BAD) ? p_bg : p_gb;
        hit       = (p == 8'hFF) || (rnd < p);
        go        = (dwell >= DWELL_MAX) && hit;

        if (en) begin
            lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);

            // The step that leaves Bad still counts as a Bad step.
            if (cur == BAD && bad_steps != '1)
                bad_nxt = bad_steps + 1'b1;

            if (go) begin
                dwell_nxt = '0;
                case (cur)
                    GOOD: begin
                        nxt    = BAD;
                        bs_nxt = 1'b1;
                        if (burst_count != '1)
                            burst_nxt = burst_count + 1'b1;
                    end
                    BAD:     nxt = GOOD;
                    default: nxt = GOOD;
                endcase
            end else if (dwell < DWELL_MAX) begin
                dwell_nxt = dwell + 8'd1;
            end
        end

        snr_nxt = (nxt == BAD) ? SNR_BAD : SNR_GOOD;

        if (stat_clr) begin
            bad_nxt   = '0;
            burst_nxt = '0;
        end
    end

endmodule

// File: tb/tb_gilbert_elliott_ctrl.sv
// Directed self-checking bench for gilbert_elliott_ctrl.
module tb_gilbert_elliott_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stat_clr;
    logic        en_a, en_b;
    logic [7:0]  p_gb_a, p_bg_a, p_gb_b, p_bg_b;

    logic        st_a, bs_a;
    logic [4:0]  snr_a;
    logic [23:0] bad_a, burst_a;
    logic        st_b, bs_b;
    logic [4:0]  snr_b;
    logic [23:0] bad_b, burst_b;
    logic        st_c, bs_c;
    logic [4:0]  snr_c;
    logic [1:0]  bad_c, burst_c;

    int checks = 0;
    int errors = 0;

    // Reference model state for the random-threshold runs (MIN_DWELL = 4).
    logic [15:0] m_lfsr;
    int          m_state, m_dwell, m_bad, m_burst, m_bs;

    gilbert_elliott_ctrl #(.MIN_DWELL(4)) dut_a (
        .clk(clk), .reset(reset), .en(en_a), .p_gb(p_gb_a), .p_bg(p_bg_a),
        .stat_clr(stat_clr), .state(st_a), .snr(snr_a), .burst_start(bs_a),
        .bad_steps(bad_a), .burst_count(burst_a)
    );

    gilbert_elliott_ctrl #(.MIN_DWELL(0)) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .p_gb(p_gb_b), .p_bg(p_bg_b),
        .stat_clr(stat_clr), .state(st_b), .snr(snr_b), .burst_start(bs_b),
        .bad_steps(bad_b), .burst_count(burst_b)
    );

    gilbert_elliott_ctrl #(.MIN_DWELL(0), .STAT_W(2)) dut_c (
        .clk(clk), .reset(reset), .en(en_b), .p_gb(p_gb_b), .p_bg(p_bg_b),
        .stat_clr(stat_clr), .state(st_c), .snr(snr_c), .burst_start(bs_c),
        .bad_steps(bad_c), .burst_count(burst_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic model_reset();
        m_lfsr  = 16'hACE1;
        m_state = 0;
        m_dwell = 0;
        m_bad   = 0;
        m_burst = 0;
        m_bs    = 0;
    endtask

    task automatic model_step(input int pgb, input int pbg);
        int rnd, p;
        bit go;
        rnd = int'(m_lfsr[7:0]);
        p   = (m_state == 1) ? pbg : pgb;
        go  = (m_dwell >= 4) && (p == 255 || rnd < p);
        m_bs = 0;
        if (m_state == 1) m_bad++;
        if (go) begin
            if (m_state == 0) begin
                m_burst++;
                m_bs = 1;
            end
            m_state = 1 - m_state;
            m_dwell = 0;
        end else if (m_dwell < 4) begin
            m_dwell++;
        end
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    initial begin
        reset = 1'b1; stat_clr = 1'b0;
        en_a = 1'b0; en_b = 1'b0;
        p_gb_a = 8'd0; p_bg_a = 8'd0; p_gb_b = 8'd0; p_bg_b = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", st_a, 0);
        chk("rst_snr", snr_a, 20);
        chk("rst_bs", bs_a, 0);
        chk("rst_bad", bad_a, 0);
        chk("rst_burst", burst_a, 0);
        chk("rst_b_state", st_b, 0);
        reset = 1'b0;

        // p_gb = 0 never leaves Good.
        p_gb_a = 8'd0; p_bg_a = 8'd255; en_a = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            chk("never_state", st_a, 0);
            chk("never_snr", snr_a, 20);
        end
        chk("never_burst", burst_a, 0);
        chk("never_bad", bad_a, 0);
        en_a = 1'b0;
        do_reset();

        // Dwell gating with p_gb = 255, p_bg = 0.
        p_gb_a = 8'd255; p_bg_a = 8'd0; en_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("dwell_state", st_a, 0);
            chk("dwell_bs", bs_a, 0);
        end
        tick();
        chk("gb_state", st_a, 1);
        chk("gb_snr", snr_a, 9);
        chk("gb_bs", bs_a, 1);
        chk("gb_burst", burst_a, 1);
        chk("gb_bad", bad_a, 0);
        en_a = 1'b0;
        tick();
        chk("hold_bs", bs_a, 0);
        chk("hold_state", st_a, 1);
        chk("hold_bad", bad_a, 0);
        chk("hold_burst", burst_a, 1);
        en_a = 1'b1;
        for (int k = 6; k <= 15; k++) begin
            tick();
            chk("bad_state", st_a, 1);
            chk("bad_bs", bs_a, 0);
        end
        chk("bad15_bad", bad_a, 10);
        chk("bad15_burst", burst_a, 1);
        en_a = 1'b0;

        // MIN_DWELL = 0 toggling, with 2-bit counter saturation on dut_c.
        p_gb_b = 8'd255; p_bg_b = 8'd255; en_b = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("tog_state", st_b, k % 2);
            chk("tog_bs", bs_b, k % 2);
            chk("tog_snr", snr_b, (k % 2) ? 9 : 20);
        end
        chk("tog_burst", burst_b, 10);
        chk("tog_bad", bad_b, 10);
        chk("sat_burst", burst_c, 3);
        chk("sat_bad", bad_c, 3);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        en_b = 1'b0;
        chk("clr_state", st_b, 1);
        chk("clr_bs", bs_b, 1);
        chk("clr_burst", burst_b, 0);
        chk("clr_bad", bad_b, 0);
        chk("clr_c_burst", burst_c, 0);
        chk("clr_c_bad", bad_c, 0);

        // Asynchronous reset two steps into a Bad burst.
        do_reset();
        p_gb_a = 8'd255; p_bg_a = 8'd0; en_a = 1'b1;
        repeat (7) tick();
        chk("mid_state", st_a, 1);
        chk("mid_bad", bad_a, 2);
        en_a = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_state", st_a, 0);
        chk("async_snr", snr_a, 20);
        chk("async_bad", bad_a, 0);
        chk("async_burst", burst_a, 0);
        tick();
        reset = 1'b0;

        // Random thresholds, en held high, sequence restarts from the seed.
        p_gb_a = 8'd128; p_bg_a = 8'd64; en_a = 1'b1;
        model_reset();
        for (int i = 0; i < 200; i++) begin
            tick();
            model_step(128, 64);
            chk("rnd_state", st_a, m_state);
            chk("rnd_bs", bs_a, m_bs);
            chk("rnd_bad", bad_a, m_bad);
            chk("rnd_burst", burst_a, m_burst);
        end
        en_a = 1'b0;
        do_reset();

        // Same thresholds with en toggling every cycle.
        model_reset();
        for (int i = 0; i < 400; i++) begin
            en_a = (i % 2 == 0);
            tick();
            if (i % 2 == 0) model_step(128, 64);
            else m_bs = 0;
            chk("en_state", st_a, m_state);
            chk("en_bs", bs_a, m_bs);
            chk("en_bad", bad_a, m_bad);
            chk("en_burst", burst_a, m_burst);
            chk("en_snr", snr_a, m_state ? 9 : 20);
        end
        en_a = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
